// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam int unsigned PC_STEP    = 32'd4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return (lsbs & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_fetch_fifo.sv
// Two-entry {pc, instr} FIFO between the fetch stage and the decoder.
module fetch_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_push_pc,
    input  logic [WIDTH-1:0] i_push_instr,
    output logic [1:0]       o_count,
    output logic [WIDTH-1:0] o_head_pc,
    output logic [WIDTH-1:0] o_head_instr
);
    import ifetch_pkg::*;

    logic [WIDTH-1:0] r_pc_mem    [0:1];
    logic [WIDTH-1:0] r_instr_mem [0:1];
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    // Qualify requests: flush wins, a full FIFO only accepts alongside a pop.
    always_comb begin
        w_pop_ok  = i_pop && !i_flush && (r_count != 2'd0);
        w_push_ok = i_push && !i_flush && ((r_count != 2'd2) || w_pop_ok);
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push_ok) r_tail <= ~r_tail;
            if (w_pop_ok)  r_head <= ~r_head;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is deliberately left unreset; validity lives in r_count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_pc_mem[r_tail]    <= i_push_pc;
            r_instr_mem[r_tail] <= i_push_instr;
        end
    end

    assign o_count      = r_count;
    assign o_head_pc    = r_pc_mem[r_head];
    assign o_head_instr = r_instr_mem[r_head];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC sequencing, redirect handling and fault detection feeding a 2-entry FIFO.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               LENGTH   = 1024,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_instr,
    output logic             fault
);
    localparam logic [WIDTH-1:0] LEN_W  = WIDTH'(LENGTH);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(PC_STEP);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_pc;
    logic [1:0]       w_count;
    logic             w_pc_bad;
    logic             w_redir_bad;
    logic             w_redir_mis;
    logic             w_pop;
    logic             w_push;

    // Alignment and range checks on the current PC and the redirect target.
    always_comb begin
        w_pc_bad    = is_misaligned(r_pc[1:0]) || ({2'b00, r_pc[WIDTH-1:2]} >= LEN_W);
        w_redir_mis = is_misaligned(redirect_pc[1:0]);
        w_redir_bad = w_redir_mis || ({2'b00, redirect_pc[WIDTH-1:2]} >= LEN_W);
        w_pop       = (w_count != 2'd0) && out_ready && !redirect_valid;
        if ((r_state == RUN) && !redirect_valid && !w_pc_bad) begin
            w_push = (w_count != 2'd2) || w_pop;
        end else begin
            w_push = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: redirects decide first, then the PC check while running.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN: begin
                if (redirect_valid) begin
                    w_next_state = w_redir_mis ? FAULT : RUN;
                end else if (w_pc_bad) begin
                    w_next_state = FAULT;
                end else begin
                    w_next_state = RUN;
                end
            end
            FAULT: begin
                if (redirect_valid && !w_redir_bad) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = FAULT;
                end
            end
            default: w_next_state = FAULT;
        endcase
    end

    // Output decode.
    always_comb begin
        out_valid = (w_count != 2'd0);
        fault     = (r_state == FAULT);
    end

    // Program counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + STEP_W;
        end else begin
            r_pc <= r_pc;
        end
    end

    assign rom_addr = {2'b00, r_pc[WIDTH-1:2]};

    fetch_fifo #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (redirect_valid),
        .i_push_pc    (r_pc),
        .i_push_instr (rom_data),
        .o_count      (w_count),
        .o_head_pc    (out_pc),
        .o_head_instr (out_instr)
    );

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus random redirect/back-pressure traffic.
module tb_ifetch;

    localparam int WIDTH  = 32;
    localparam int LENGTH = 1024;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] rom_addr;
    logic [WIDTH-1:0] rom_data;
    logic             redirect_valid = 1'b0;
    logic [WIDTH-1:0] redirect_pc = 32'h0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_instr;
    logic             fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;
    logic        mfault;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          n_checks = 0;

    ifetch #(.WIDTH(WIDTH), .LENGTH(LENGTH), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] word_idx);
        if (word_idx < LENGTH) return 32'h1000 + word_idx;
        return 32'hDEAD_BEEF;
    endfunction

    always_comb rom_data = rom_word(rom_addr);

    function automatic bit pc_ok(input logic [31:0] pc);
        return (pc % 4 == 0) && (pc / 4 < LENGTH);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc    = 32'h0;
        mfault = 1'b0;
    endtask

    // Reference behaviour for one rising edge, using the inputs applied to it.
    task automatic model_edge();
        bit popped;
        popped = (mq.size() != 0) && out_ready;
        if (redirect_valid) begin
            mq.delete();
            mpc = redirect_pc;
            if (redirect_pc % 4 != 0)             mfault = 1'b1;
            else if (mfault && !pc_ok(redirect_pc)) mfault = 1'b1;
            else                                   mfault = 1'b0;
        end else begin
            if (popped) void'(mq.pop_front());
            if (!mfault) begin
                if (!pc_ok(mpc)) begin
                    mfault = 1'b1;
                end else if (mq.size() < 2) begin
                    mq.push_back('{pc: mpc, instr: rom_word(mpc / 4)});
                    mpc = mpc + 32'd4;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, {31'b0, out_valid}, {31'b0, mq.size() != 0});
        check({tag, ".fault"}, {31'b0, fault}, {31'b0, mfault});
        check({tag, ".rom_addr"}, rom_addr, mpc / 4);
        if (mq.size() != 0) begin
            check({tag, ".out_pc"}, out_pc, mq[0].pc);
            check({tag, ".out_instr"}, out_instr, mq[0].instr);
        end
    endtask

    task automatic step(input string tag, input logic redir, input logic [31:0] rpc, input logic rdy);
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rpc;
        // Power-on reset.
        #2;
        model_reset();
        check_all("por");
        do_reset();

        // Streaming with decoder always ready.
        step("stream0", 1'b0, 32'h0, 1'b1);
        check("stream0.pc", out_pc, 32'h0);
        check("stream0.instr", out_instr, 32'h1000);
        for (int i = 0; i < 4; i++) step("stream", 1'b0, 32'h0, 1'b1);

        // Back-pressure right after reset.
        do_reset();
        for (int i = 0; i < 5; i++) step("stall", 1'b0, 32'h0, 1'b0);
        check("stall.rom_addr", rom_addr, 32'd2);
        check("stall.head", out_pc, 32'h0);
        for (int i = 0; i < 4; i++) step("resume", 1'b0, 32'h0, 1'b1);

        // Redirect with two buffered entries.
        step("fill", 1'b0, 32'h0, 1'b0);
        step("fill", 1'b0, 32'h0, 1'b0);
        step("redir40", 1'b1, 32'h40, 1'b1);
        check("redir40.flush", {31'b0, out_valid}, 32'h0);
        step("redir40b", 1'b0, 32'h0, 1'b1);
        check("redir40.pc", out_pc, 32'h40);
        check("redir40.instr", out_instr, 32'h1010);
        step("after40", 1'b0, 32'h0, 1'b1);

        // Misaligned redirect, then recovery.
        step("mis", 1'b1, 32'h42, 1'b1);
        check("mis.fault", {31'b0, fault}, 32'h1);
        for (int i = 0; i < 3; i++) step("infault", 1'b0, 32'h0, 1'b1);
        step("recover", 1'b1, 32'h8, 1'b1);
        check("recover.fault", {31'b0, fault}, 32'h0);
        step("recover1", 1'b0, 32'h0, 1'b1);
        check("recover1.pc", out_pc, 32'h8);

        // End of ROM.
        step("end", 1'b1, 32'hFF8, 1'b1);
        for (int i = 0; i < 5; i++) step("endrun", 1'b0, 32'h0, 1'b1);
        check("end.fault", {31'b0, fault}, 32'h1);
        check("end.rom_addr", rom_addr, 32'h400);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0:       rpc = $urandom_range(0, 255) * 4;
                1:       rpc = 32'hFE0 + $urandom_range(0, 12) * 4;
                2:       rpc = ($urandom_range(0, 255) * 4) | $urandom_range(1, 3);
                3:       rpc = 32'hFFFF_FFF0 + $urandom_range(0, 3) * 4;
                default: rpc = $urandom;
            endcase
            step("rand", ($urandom_range(0, 11) == 0), rpc, ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset mid-burst with a full FIFO, recovered to normal flow.
        step("prep", 1'b1, 32'h100, 1'b0);
        step("prep", 1'b0, 32'h0, 1'b0);
        step("prep", 1'b0, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async.valid", {31'b0, out_valid}, 32'h0);
        check("async.fault", {31'b0, fault}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("restart", 1'b0, 32'h0, 1'b1);

        // Asynchronous reset while faulted.
        step("prepf", 1'b1, 32'h81, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("asyncf.fault", {31'b0, fault}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("restartf", 1'b0, 32'h0, 1'b1);
        check("restartf.pc", out_pc, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter WIDTH, default 32, data and PC width in bits.
REQ-002 Parameter LENGTH, default 1024, program ROM depth in 32-bit words.
REQ-003 Parameter RESET_PC, default 0, byte address fetched first after reset.
REQ-004 clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 rom_addr  output  WIDTH  word index to the ROM, equal to pc >> 2.
REQ-007 rom_data  input  WIDTH  ROM word at rom_addr, valid in the same cycle (combinational ROM).
REQ-008 redirect_valid  input  1  branch/jump request, sampled each cycle.
REQ-009 redirect_pc  input  WIDTH  byte target of the redirect.
REQ-010 out_valid  output  1  head entry available to the decoder.
REQ-011 out_ready  input  1  decoder accepts the head entry.
REQ-012 out_pc  output  WIDTH  byte PC of the head entry.
REQ-013 out_instr  output  WIDTH  instruction word of the head entry.
REQ-014 fault  output  1  high while in the FAULT state.

Function
REQ-015 States are RUN and FAULT; the initial state is RUN.
REQ-016 In RUN, push {pc, rom_data} into a 2-entry FIFO when count<2, or count==2 with a pop that cycle, and no redirect; then pc <= pc+4.
REQ-017 A pop occurs when out_valid and out_ready are both high; the head then advances.
REQ-018 out_valid equals count!=0; out_pc/out_instr come from the registered head, with no combinational path from rom_data.
REQ-019 Fetch-to-output latency is 1 cycle: a word pushed at edge N is visible at the output after edge N.
REQ-020 With a push and a pop in the same cycle, count is unchanged and order is preserved.
REQ-021 redirect_valid has priority over push and pop: FIFO flushed (count<=0), pc<=redirect_pc, no push, any pop that cycle discarded.
REQ-022 A redirect with redirect_pc[1:0]!=0 enters FAULT; pc is loaded with redirect_pc.
REQ-023 In RUN, if pc[1:0]!=0 or pc>>2 >= LENGTH, nothing is pushed and the state becomes FAULT next edge.
REQ-024 In FAULT no pushes occur; entries already in the FIFO still drain normally.
REQ-025 In FAULT, an aligned, in-range redirect returns the state to RUN; any other redirect keeps the state in FAULT.
REQ-026 PC arithmetic is modulo 2^WIDTH; wrap-around is caught by the range check in REQ-023.
REQ-027 rom_addr is driven in every state, including FAULT.

Reset
REQ-028 On rst_n low, asynchronously: pc=RESET_PC, count=0, head/tail pointers=0, state=RUN, out_valid=0, fault=0.
REQ-029 Reset mid-operation discards all FIFO contents; entry data registers are not reset, and out_pc/out_instr are don't-care while out_valid=0.
REQ-030 First fetch occurs on the first rising edge with rst_n high.

Structure
REQ-031 Shared package ifetch_pkg holds the state enum {RUN, FAULT}, the constant PC_STEP=4 and the constant ALIGN_MASK=2'b11.
REQ-032 Sub-module fetch_fifo implements the 2-entry {pc,instr} FIFO with push, pop, flush, count, head outputs; ifetch holds pc, the FSM and the checks.

Verification
REQ-033 Reset release with out_ready=1 and ROM word k = 0x1000+k -> one edge later out_pc=0, out_instr=0x1000; then one entry per cycle with pc +4.
REQ-034 out_ready=0 for 5 cycles after reset -> count=2, entries pc 0 and 4 held; rom_addr stays 2; raising out_ready resumes with no loss or duplication.
REQ-035 redirect_pc=0x40 while 2 entries are buffered and out_ready=1 -> next cycle out_valid=0; the following cycle out_pc=0x40, out_instr=0x1010.
REQ-036 redirect_pc=0x42 -> fault=1, no further pushes; then redirect_pc=0x8 -> fault=0, out_pc=0x8 appears one cycle later.
REQ-037 LENGTH=1024, redirect_pc=0xFF8 -> entries 0xFF8 and 0xFFC are delivered, then fault=1 with pc=0x1000 and no push.
REQ-038 rst_n asserted asynchronously mid-burst with count=2 -> out_valid=0 and fault=0 immediately; restart from RESET_PC.
